// File: rtl/synth_cfg_sequencer.sv
// synth_cfg_sequencer: FIFO-buffered, strobe-timed writer for the synth config port.
// Optional flush input enabled by defining SYNTH_CFG_SEQ_FLUSH_EN.
module synth_cfg_sequencer #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 4,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_addr,
  input  logic [7:0]               in_data,
  output logic [3:0]               cfg_addr,
  output logic [7:0]               cfg_data,
  output logic                     cfg_strobe,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
`ifdef SYNTH_CFG_SEQ_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int MAX_SG =
    (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int MAXP =
    (MAX_SG > STROBE_CYCLES) ? MAX_SG : STROBE_CYCLES;
  localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_FULL =
    (FIFO_DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [11:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr;
  logic [FIFO_DEPTH_LOG2-1:0] rptr;
  logic [11:0]                head;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;

  assign head       = mem[rptr];
  assign fifo_empty = (fifo_level == '0);
  assign push       = in_valid & in_ready;
  assign busy       = (state != IDLE) | !fifo_empty;

`ifdef SYNTH_CFG_SEQ_FLUSH_EN
  assign in_ready = (fifo_level != LVL_FULL) & !flush;
  assign pop = !fifo_empty & !flush &
               ((state == IDLE) | ((state == GAP) & (cnt == '0)));
`else
  assign in_ready = (fifo_level != LVL_FULL);
  assign pop = !fifo_empty &
               ((state == IDLE) | ((state == GAP) & (cnt == '0)));
`endif

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_addr, in_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end
`ifdef SYNTH_CFG_SEQ_FLUSH_EN
    else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end
`endif
    else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
      if (push && !pop) fifo_level <= fifo_level + LVL_ONE;
      else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;
    end
  end

  // Setup / strobe / gap sequencer with registered pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_strobe <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            {cfg_addr, cfg_data} <= head;
            state <= SETUP;
            cnt   <= SETUP_LD;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cfg_strobe <= 1'b1;
            state      <= STROBE;
            cnt        <= STROBE_LD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            cfg_strobe <= 1'b0;
            state      <= GAP;
            cnt        <= GAP_LD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (pop) begin
              {cfg_addr, cfg_data} <= head;
              state <= SETUP;
              cnt   <= SETUP_LD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_cfg_sequencer.sv
// Scoreboard bench for synth_cfg_sequencer with a synth capture model.
// Expected writes queue at handshake; a negedge monitor checks each strobe.
`timescale 1ns/1ps
module tb_synth_cfg_sequencer;

  localparam int SETUP = 2;
  localparam int STRB  = 4;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_strobe;
  logic       busy;
  logic [2:0] fifo_level;
`ifdef SYNTH_CFG_SEQ_FLUSH_EN
  logic       flush = 1'b0;
`endif

  always #5 clk = ~clk;

  synth_cfg_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_data(in_data),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_strobe(cfg_strobe),
    .busy(busy),
    .fifo_level(fifo_level)
`ifdef SYNTH_CFG_SEQ_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rises = 0;
  int caps = 0;
  logic [11:0] exp_q[$];
  int rise_t[$];
  logic [15:0] ref_cfg[8];
  logic [15:0] syn_cfg[8];
  bit ovr_mode = 0;
  bit ovr_all = 0;
  bit ovr_rand = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ovr_rand = 1'($urandom_range(0, 1));

  // Synth model: two-flop sync, level-armed capture, override steals a cycle
  logic s1, s2, s2d, ovr;
  bit armed;
  assign ovr = s2 & ~s2d & (ovr_all | (ovr_mode & ovr_rand));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 0; s2 <= 0; s2d <= 0; armed <= 1;
      for (int i = 0; i < 8; i++) syn_cfg[i] <= '0;
    end else begin
      s1 <= cfg_strobe; s2 <= s1; s2d <= s2;
      if (!s2) armed <= 1;
      else if (armed && !ovr) begin
        if (cfg_addr[0]) syn_cfg[cfg_addr[3:1]][15:8] <= cfg_data;
        else syn_cfg[cfg_addr[3:1]][7:0] <= cfg_data;
        caps <= caps + 1;
        armed <= 0;
      end
    end
  end

  // Monitor: payload order, setup/hold stability, pulse width, low gap
  logic prev_s;
  int low_run, high_run, stab, hold_left;
  bit seen_pulse;
  logic [11:0] last_cfg, held, cur, e;
  always @(negedge clk) begin
    cur = {cfg_addr, cfg_data};
    if (!rst_n) begin
      prev_s = 0; low_run = 0; high_run = 0; stab = 0;
      hold_left = 0; seen_pulse = 0; last_cfg = cur;
    end else begin
      if (cur == last_cfg) stab++; else stab = 0;
      last_cfg = cur;
      if (cfg_strobe && !prev_s) begin
        rises++;
        rise_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got %0h want none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_payload", 32'(cur), 32'(e));
        end
        chk("setup_stable", 32'(stab >= SETUP), 1);
        if (seen_pulse) chk("low_gap", 32'(low_run >= SETUP + GAP), 1);
        held = cur;
        high_run = 0;
      end
      if (cfg_strobe) begin
        high_run++;
        chk("hold_high", 32'(cur), 32'(held));
      end
      if (!cfg_strobe && prev_s) begin
        chk("pulse_width", high_run, STRB);
        seen_pulse = 1; low_run = 0; hold_left = GAP;
      end
      if (!cfg_strobe) begin
        low_run++;
        if (hold_left > 0) begin
          chk("hold_gap", 32'(cur), 32'(held));
          hold_left--;
        end
      end
      prev_s = cfg_strobe;
    end
  end

  task automatic do_reset();
    in_valid = 0;
`ifdef SYNTH_CFG_SEQ_FLUSH_EN
    flush = 0;
`endif
    rst_n = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) ref_cfg[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1; in_addr = a; in_data = d;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout: got ready=0 want 1");
      in_valid = 0;
      acc = cyc;
    end else begin
      exp_q.push_back({a, d});
      if (a[0]) ref_cfg[a[3:1]][15:8] = d;
      else ref_cfg[a[3:1]][7:0] = d;
      @(posedge clk);
      #1;
      in_valid = 0;
      acc = cyc;
    end
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=1 want 0");
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic cmp_regs(input string name);
    for (int i = 0; i < 8; i++) chk(name, 32'(syn_cfg[i]), 32'(ref_cfg[i]));
  endtask

  initial begin
    int t0, acc, c0, n, r0;
    // reset state
    do_reset();
    #1;
    chk("rst_strobe", 32'(cfg_strobe), 0);
    chk("rst_addr", 32'(cfg_addr), 0);
    chk("rst_data", 32'(cfg_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ready", 32'(in_ready), 1);

    // single write timing
    c0 = caps;
    push(4'h5, 8'hA7, t0);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("sw_addr", 32'(cfg_addr), 5);
        chk("sw_data", 32'(cfg_data), 32'hA7);
      end
      chk($sformatf("sw_strobe_e%0d", k), 32'(cfg_strobe),
          32'(k >= 3 && k <= 6));
      if (k == 10) chk("sw_busy_e10", 32'(busy), 1);
      if (k == 11) chk("sw_busy_e11", 32'(busy), 0);
    end
    repeat (4) @(negedge clk);
    chk("sw_synth_reg", 32'(syn_cfg[2][15:8]), 32'hA7);
    chk("sw_caps", caps - c0, 1);

    // overflow and back-to-back cadence
    do_reset();
    rise_t.delete();
    push(4'h0, 8'h10, t0);
    for (int i = 1; i < 5; i++) push(4'(i), 8'(8'h10 + i), acc);
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_ready", 32'(in_ready), 0);
    for (int k = 5; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) chk("ovf_ready_e10", 32'(in_ready), 0);
      if (k == 11) chk("ovf_ready_e11", 32'(in_ready), 1);
    end
    push(4'h5, 8'h15, acc);
    wait_idle(200);
    chk("ovf_rises", rise_t.size(), 6);
    for (int i = 0; i < 5 && i < rise_t.size(); i++)
      chk($sformatf("ovf_rise%0d", i), rise_t[i] - t0, 3 + 10 * i);
    cmp_regs("ovf_regs");

    // override on every synced rise
    do_reset();
    ovr_all = 1;
    c0 = caps;
    push(4'h3, 8'h5C, acc);
    push(4'hE, 8'hC3, acc);
    wait_idle(100);
    repeat (6) @(negedge clk);
    chk("ovr_caps", caps - c0, 2);
    cmp_regs("ovr_regs");
    ovr_all = 0;

    // random back-to-back then random spacing, random overrides
    do_reset();
    ovr_mode = 1;
    c0 = caps;
    for (int i = 0; i < 3; i++)
      push(4'($urandom_range(0, 15)), 8'($urandom), acc);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      push(4'($urandom_range(0, 15)), 8'($urandom), acc);
    end
    wait_idle(600);
    repeat (6) @(negedge clk);
    chk("rnd_caps", caps - c0, 23);
    cmp_regs("rnd_regs");
    ovr_mode = 0;

    // asynchronous reset during STROBE
    do_reset();
    push(4'h1, 8'h22, acc);
    push(4'h2, 8'h33, acc);
    n = 0;
    while (!cfg_strobe && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mr_reach_strobe", 32'(cfg_strobe), 1);
    #2;
    rst_n = 0;
    #1;
    chk("mr_strobe", 32'(cfg_strobe), 0);
    chk("mr_level", 32'(fifo_level), 0);
    chk("mr_busy", 32'(busy), 0);
    exp_q.delete();
    do_reset();
    repeat (20) @(negedge clk);
    chk("mr_quiet", 32'(cfg_strobe), 0);

`ifdef SYNTH_CFG_SEQ_FLUSH_EN
    // flush during the first STROBE
    do_reset();
    push(4'h4, 8'h41, acc);
    push(4'h6, 8'h42, acc);
    push(4'h8, 8'h43, acc);
    n = 0;
    while (!cfg_strobe && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fl_reach_strobe", 32'(cfg_strobe), 1);
    flush = 1;
    #1;
    exp_q.delete();
    r0 = rises;
    chk("fl_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("fl_level", 32'(fifo_level), 0);
    @(negedge clk);
    flush = 0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fl_busy_fall", cyc - rise_t[$], STRB + GAP);
    repeat (30) @(negedge clk);
    chk("fl_no_pulse", rises - r0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
